// File: rtl/pix_bitplane_tx.sv
// rtl/pix_bitplane_tx.sv - streams a square picture as LSB-first bit-plane beats
// Each pixel is fetched from memory and sent as 8 replicated-bit words with idle gaps and ready handshake.
module pix_bitplane_tx #(
    parameter int DW       = 128,
    parameter int AW       = 10,
    parameter int BEAT_GAP = 5
) (
    input  logic          sys_clk,
    input  logic          SYS_NRST,
    input  logic          START,
    input  logic [7:0]    PIC_SIZE,
    input  logic [AW-1:0] RADDR_START,
    output logic [AW-1:0] PIX_RADDR,
    output logic          PIX_REN,
    input  logic [7:0]    PIX_RDATA,
    output logic [DW-1:0] DATA,
    output logic          DATA_VLD,
    output logic          DATA_SOP,
    output logic          DATA_HSYNC,
    input  logic          WREADY,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR
);

    localparam int GW = (BEAT_GAP > 1) ? $clog2(BEAT_GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'((BEAT_GAP > 0) ? BEAT_GAP - 1 : 0);

    typedef enum logic [3:0] {
        IDLE, SOP, SOPGAP, RD, RDW, GAP, WAITRDY, BEAT, HSYNC, FIN
    } state_t;

    // With no gap configured the fetch goes straight to the ready wait.
    localparam state_t FETCH_NEXT = (BEAT_GAP == 0) ? WAITRDY : GAP;

    state_t        state;
    logic [7:0]    size;
    logic [7:0]    x;
    logic [7:0]    y;
    logic [2:0]    bit_idx;
    logic [7:0]    pix;
    logic [AW-1:0] row_addr;
    logic [GW-1:0] gap_cnt;
    logic          wrdy_q;

    logic [7:0]    last;
    logic [7:0]    x_nxt;
    logic [2:0]    bit_nxt;

    always_comb begin
        last    = size - 8'd1;
        x_nxt   = x + 8'd1;
        bit_nxt = bit_idx + 3'd1;
    end

    // row_addr tracks RADDR_START + y*size so no multiplier is needed.
    always_ff @(posedge sys_clk or posedge SYS_NRST) begin
        if (SYS_NRST) begin
            state      <= IDLE;
            size       <= '0;
            x          <= '0;
            y          <= '0;
            bit_idx    <= '0;
            pix        <= '0;
            row_addr   <= '0;
            gap_cnt    <= '0;
            wrdy_q     <= 1'b0;
            PIX_RADDR  <= '0;
            PIX_REN    <= 1'b0;
            DATA       <= '0;
            DATA_VLD   <= 1'b0;
            DATA_SOP   <= 1'b0;
            DATA_HSYNC <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            DATA_SOP   <= 1'b0;
            DATA_HSYNC <= 1'b0;
            DATA_VLD   <= 1'b0;
            PIX_REN    <= 1'b0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
            wrdy_q     <= WREADY;
            case (state)
                IDLE: begin
                    if (START) begin
                        if (PIC_SIZE >= 8'd3) begin
                            size     <= PIC_SIZE;
                            row_addr <= RADDR_START;
                            x        <= '0;
                            y        <= '0;
                            bit_idx  <= '0;
                            BUSY     <= 1'b1;
                            DATA_SOP <= 1'b1;
                            state    <= SOP;
                        end else begin
                            ERR <= 1'b1;
                        end
                    end
                end
                SOP: begin
                    if (BEAT_GAP == 0) begin
                        PIX_REN   <= 1'b1;
                        PIX_RADDR <= row_addr;
                        state     <= RD;
                    end else begin
                        gap_cnt <= GAP_LOAD;
                        state   <= SOPGAP;
                    end
                end
                SOPGAP: begin
                    if (gap_cnt == '0) begin
                        PIX_REN   <= 1'b1;
                        PIX_RADDR <= row_addr;
                        state     <= RD;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                RD: state <= RDW;
                RDW: begin
                    pix     <= PIX_RDATA;
                    DATA    <= {DW{PIX_RDATA[bit_idx]}};
                    gap_cnt <= GAP_LOAD;
                    state   <= FETCH_NEXT;
                end
                GAP: begin
                    if (gap_cnt == '0) state <= WAITRDY;
                    else gap_cnt <= gap_cnt - 1'b1;
                end
                WAITRDY: begin
                    if (wrdy_q) begin
                        DATA_VLD <= 1'b1;
                        state    <= BEAT;
                    end
                end
                BEAT: begin
                    if (bit_idx != 3'd7) begin
                        bit_idx <= bit_nxt;
                        DATA    <= {DW{pix[bit_nxt]}};
                        gap_cnt <= GAP_LOAD;
                        state   <= FETCH_NEXT;
                    end else begin
                        bit_idx <= '0;
                        if (x == last) begin
                            DATA_HSYNC <= 1'b1;
                            state      <= HSYNC;
                        end else begin
                            x         <= x_nxt;
                            PIX_REN   <= 1'b1;
                            PIX_RADDR <= row_addr + AW'(x_nxt);
                            state     <= RD;
                        end
                    end
                end
                HSYNC: begin
                    if (y == last) begin
                        DONE  <= 1'b1;
                        state <= FIN;
                    end else begin
                        x         <= '0;
                        y         <= y + 8'd1;
                        row_addr  <= row_addr + AW'(size);
                        PIX_REN   <= 1'b1;
                        PIX_RADDR <= row_addr + AW'(size);
                        state     <= RD;
                    end
                end
                FIN: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pix_bitplane_tx.sv
// tb/tb_pix_bitplane_tx.sv - scoreboard bench for pix_bitplane_tx
// Expected read addresses and beat words are queued at frame start and popped as the DUT emits them.
module tb_pix_bitplane_tx;

    localparam int DW       = 128;
    localparam int AW       = 10;
    localparam int BEAT_GAP = 5;

    logic          sys_clk     = 1'b0;
    logic          SYS_NRST    = 1'b1;
    logic          START       = 1'b0;
    logic [7:0]    PIC_SIZE    = '0;
    logic [AW-1:0] RADDR_START = '0;
    logic [AW-1:0] PIX_RADDR;
    logic          PIX_REN;
    logic [7:0]    PIX_RDATA   = '0;
    logic [DW-1:0] DATA;
    logic          DATA_VLD;
    logic          DATA_SOP;
    logic          DATA_HSYNC;
    logic          WREADY      = 1'b1;
    logic          BUSY;
    logic          DONE;
    logic          ERR;

    pix_bitplane_tx #(.DW(DW), .AW(AW), .BEAT_GAP(BEAT_GAP)) dut (
        .sys_clk(sys_clk), .SYS_NRST(SYS_NRST), .START(START),
        .PIC_SIZE(PIC_SIZE), .RADDR_START(RADDR_START),
        .PIX_RADDR(PIX_RADDR), .PIX_REN(PIX_REN), .PIX_RDATA(PIX_RDATA),
        .DATA(DATA), .DATA_VLD(DATA_VLD), .DATA_SOP(DATA_SOP), .DATA_HSYNC(DATA_HSYNC),
        .WREADY(WREADY), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 sys_clk = ~sys_clk;

    logic [7:0] mem [0:(1<<AW)-1];
    always @(posedge sys_clk) if (PIX_REN) PIX_RDATA <= mem[PIX_RADDR];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic          beat_q [$];
    logic [AW-1:0] addr_q [$];
    bit mon_en   = 1'b0;
    int cur_size = 0;
    int beats = 0, hsyncs = 0, sops = 0, dones = 0;

    always @(negedge sys_clk) if (mon_en) begin
        if (DATA_SOP | DATA_HSYNC | DATA_VLD)
            check("excl", DW'($countones({DATA_SOP, DATA_HSYNC, DATA_VLD})), DW'(1));
        if (PIX_REN) begin
            check("addr_avail", DW'(addr_q.size() > 0), DW'(1));
            if (addr_q.size() > 0) check("raddr", DW'(PIX_RADDR), DW'(addr_q.pop_front()));
        end
        if (DATA_VLD) begin
            check("beat_avail", DW'(beat_q.size() > 0), DW'(1));
            if (beat_q.size() > 0) check("beat", DATA, {DW{beat_q.pop_front()}});
            beats++;
        end
        if (DATA_SOP) sops++;
        if (DATA_HSYNC) begin
            hsyncs++;
            check("hsync_pos", DW'(beats), DW'(8 * cur_size * hsyncs));
        end
        if (DONE) begin
            dones++;
            check("done_beats", DW'(beats), DW'(8 * cur_size * cur_size));
            check("done_hsync", DW'(hsyncs), DW'(cur_size));
            check("done_sop", DW'(sops), DW'(1));
            check("done_qempty", DW'(beat_q.size() + addr_q.size()), DW'(0));
        end
    end

    task automatic start_frame(input int size, input int base);
        int a;
        cur_size = size;
        beats = 0; hsyncs = 0; sops = 0; dones = 0;
        for (int y = 0; y < size; y++)
            for (int x = 0; x < size; x++) begin
                a = (base + y * size + x) % (1 << AW);
                addr_q.push_back(AW'(a));
                for (int b = 0; b < 8; b++) beat_q.push_back(mem[a][b]);
            end
        @(posedge sys_clk); #1;
        PIC_SIZE = 8'(size); RADDR_START = AW'(base); START = 1'b1;
        @(posedge sys_clk); #1;
        START = 1'b0;
        check("busy_on", DW'(BUSY), DW'(1));
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (dones == 0 && n < budget) begin
            @(posedge sys_clk);
            n++;
        end
        check("done_seen", DW'(dones), DW'(1));
        #1;
        check("busy_off", DW'(BUSY), DW'(0));
        check("done_pulse", DW'(DONE), DW'(0));
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_data"}, DATA, '0);
        check({tag, "_ctl"}, DW'({PIX_RADDR, PIX_REN, DATA_VLD, DATA_SOP, DATA_HSYNC, BUSY, DONE, ERR}), DW'(0));
    endtask

    initial begin
        int n;
        for (int a = 0; a < (1 << AW); a++) mem[a] = 8'(a);

        repeat (3) @(posedge sys_clk);
        #1;
        check_outs_zero("reset");
        SYS_NRST = 1'b0;
        mon_en   = 1'b1;

        // Undersized picture is rejected with a single ERR pulse.
        @(posedge sys_clk); #1;
        PIC_SIZE = 8'd2; START = 1'b1;
        @(posedge sys_clk); #1;
        START = 1'b0;
        check("err_pulse", DW'(ERR), DW'(1));
        check("err_busy", DW'(BUSY), DW'(0));
        @(posedge sys_clk); #1;
        check("err_clear", DW'(ERR), DW'(0));
        check("err_idle", DW'(BUSY), DW'(0));

        // Full 8x8 frame with a stray START mid-frame.
        start_frame(8, 0);
        repeat (300) @(posedge sys_clk);
        #1;
        PIC_SIZE = 8'd3; RADDR_START = AW'(100); START = 1'b1;
        @(posedge sys_clk); #1;
        START = 1'b0;
        check("busy_start_err", DW'(ERR), DW'(0));
        wait_done(20000);

        // 3x3 frame, first pixel 0x05.
        mem[0] = 8'h05;
        start_frame(3, 0);
        wait_done(5000);

        // Backpressure held in WAITRDY for 40 cycles.
        WREADY = 1'b0;
        start_frame(3, 0);
        repeat (20) @(posedge sys_clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            check("bp_vld", DW'(DATA_VLD), DW'(0));
            check("bp_data", DATA, {DW{1'b1}});
        end
        @(posedge sys_clk); #1;
        WREADY = 1'b1;
        @(posedge sys_clk); #1;
        check("bp_vld_1", DW'(DATA_VLD), DW'(0));
        @(posedge sys_clk); #1;
        check("bp_vld_2", DW'(DATA_VLD), DW'(1));
        wait_done(5000);

        // Reset after 100 beats aborts the frame; restart begins cleanly.
        start_frame(8, 0);
        n = 0;
        while (beats < 100 && n < 10000) begin
            @(posedge sys_clk);
            n++;
        end
        check("reach_100", DW'(beats >= 100), DW'(1));
        @(negedge sys_clk); #2;
        mon_en   = 1'b0;
        SYS_NRST = 1'b1;
        #1;
        check_outs_zero("midrst");
        beat_q.delete();
        addr_q.delete();
        @(posedge sys_clk); #1;
        SYS_NRST = 1'b0;
        dones = 0;
        mon_en = 1'b1;
        repeat (20) @(posedge sys_clk);
        check("no_done_after_abort", DW'(dones), DW'(0));
        start_frame(3, 7);
        wait_done(5000);

        // Address wrap at the top of the pixel memory.
        start_frame(3, 1020);
        wait_done(5000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pix_bitplane_tx.md
PIX_BITPLANE_TX -- requirements
Module: pix_bitplane_tx

Interface
REQ-001 SHALL have parameter DW, default 128, width of the bit-plane data word.
REQ-002 SHALL have parameter AW, default 10, pixel-memory address width.
REQ-003 SHALL have parameter BEAT_GAP, default 5, idle cycles inserted before each beat and after SOP.
REQ-004 SHALL have port sys_clk  input  1  clock; all logic rising-edge.
REQ-005 SHALL have port SYS_NRST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port START  input  1  one-cycle frame start request.
REQ-007 SHALL have port PIC_SIZE  input  8  square picture edge length in pixels, sampled at accepted START.
REQ-008 SHALL have port RADDR_START  input  AW  first pixel address, sampled at accepted START.
REQ-009 SHALL have port PIX_RADDR  output  AW  pixel memory read address.
REQ-010 SHALL have port PIX_REN  output  1  pixel memory read enable.
REQ-011 SHALL have port PIX_RDATA  input  8  pixel byte, valid exactly 1 cycle after PIX_REN.
REQ-012 SHALL have port DATA  output  DW  current bit-plane word.
REQ-013 SHALL have port DATA_VLD  output  1  one-cycle beat strobe.
REQ-014 SHALL have port DATA_SOP  output  1  one-cycle start-of-picture pulse.
REQ-015 SHALL have port DATA_HSYNC  output  1  one-cycle end-of-row pulse.
REQ-016 SHALL have port WREADY  input  1  receiver ready to accept a beat.
REQ-017 SHALL have ports BUSY, DONE, ERR  output  1 each  frame active / one-cycle frame complete / one-cycle rejected-start.

Function
REQ-018 SHALL implement states IDLE, SOP, SOPGAP, RD, RDW, GAP, WAITRDY, BEAT, HSYNC, FIN.
REQ-019 IDLE + START with PIC_SIZE>=3 SHALL latch PIC_SIZE/RADDR_START, clear x, y, bit, go SOP; BUSY=1 from next cycle until FIN exits.
REQ-020 START with PIC_SIZE<3 in IDLE SHALL pulse ERR one cycle later and remain IDLE; START while BUSY SHALL be ignored (no ERR).
REQ-021 SOP SHALL drive DATA_SOP=1 for exactly one cycle, then SOPGAP holds BEAT_GAP cycles, then RD.
REQ-022 RD SHALL assert PIX_REN one cycle with PIX_RADDR=RADDR_START+y*PIC_SIZE+x (AW bits, wrap mod 2^AW); RDW SHALL capture PIX_RDATA into an 8-bit pixel register.
REQ-023 Pixels SHALL be sent row-major: x 0..PIC_SIZE-1 within row y, y 0..PIC_SIZE-1.
REQ-024 Each pixel SHALL produce exactly 8 beats, LSB first (bit 0..7); DATA SHALL equal {DW{pixel[bit]}} and be stable from GAP entry through BEAT.
REQ-025 GAP SHALL hold BEAT_GAP cycles (0 = skip), then WAITRDY.
REQ-026 WAITRDY SHALL move to BEAT in the cycle after WREADY sampled 1; waits indefinitely while WREADY=0.
REQ-027 BEAT SHALL assert DATA_VLD for exactly one cycle; DATA_VLD never asserted outside BEAT.
REQ-028 After beat with bit<7: bit+1, go GAP. After bit 7: bit=0; if x=PIC_SIZE-1 go HSYNC, else x+1, go RD.
REQ-029 HSYNC SHALL drive DATA_HSYNC=1 one cycle with DATA_VLD=0; then if y=PIC_SIZE-1 go FIN, else x=0, y+1, go RD.
REQ-030 FIN SHALL pulse DONE one cycle, drop BUSY, return IDLE.
REQ-031 DATA_SOP, DATA_HSYNC, DATA_VLD SHALL be mutually exclusive in every cycle.
REQ-032 Total beats per frame SHALL be 8*PIC_SIZE^2; HSYNC pulses SHALL be PIC_SIZE.
REQ-033 All outputs SHALL be registered; x, y counters 8 bits, bit counter 3 bits.

Reset
REQ-034 SYS_NRST=1 SHALL asynchronously force IDLE and all outputs (DATA, DATA_VLD, DATA_SOP, DATA_HSYNC, PIX_REN, PIX_RADDR, BUSY, DONE, ERR) to 0.
REQ-035 Reset mid-frame SHALL abort without DONE; after release, new START begins a fresh frame from pixel (0,0) bit 0.

Verification
REQ-036 PIC_SIZE=8, WREADY=1, BEAT_GAP=5, memory[a]=a: SHALL see 1 SOP, 512 beats, 8 HSYNC, 1 DONE; beat n of pixel p carries {128{p[n]}}.
REQ-037 PIC_SIZE=3, pixel 0x05: beats bit0..7 SHALL be all-ones, zeros, all-ones, then five all-zero words; HSYNC after 24th beat.
REQ-038 WREADY held 0 for 40 cycles in WAITRDY: DATA_VLD SHALL stay 0, DATA stable; first VLD exactly 2 cycles after WREADY rises.
REQ-039 START with PIC_SIZE=2: ERR one-cycle pulse, BUSY stays 0; second START during a frame: no effect on beat count.
REQ-040 SYS_NRST asserted after 100 beats: all outputs 0 immediately; restart yields first beat = bit 0 of pixel at RADDR_START.
REQ-041 RADDR_START=1020, AW=10, PIC_SIZE=3: PIX_RADDR sequence SHALL wrap 1020..1023,0..4.
